bus2st_pp: RTL and testbench



---
 rtl/bus2st_pp.sv | 203 ++++++++++++++++++++
 tb/tb_bus2st_pp.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus2st_pp.sv
// bus2st_pp -- ping-pong bus-word to Avalon-ST symbol stream converter.
//
// A writer pushes wide bus words into one of two banks; each bank holds one
// turbo packet (BUS_PER_PKT words).  When a bank is FULL the read FSM streams
// its symbols out LSB-first, word 0 first, while the writer fills the other
// bank.  The final word of a packet is only partially used.
//
// Ports
//   clk_st    : sole clock, rising edge
//   rst       : synchronous, active-high reset
//   bus_data  : input word, symbol k at [k*ST_W +: ST_W]
//   bus_en    : word write strobe
//   bus_ready : current write bank can take a word
//   st_ready  : sink ready (ready latency 0)
//   st_data   : output symbol
//   st_valid  : st_data valid
//   st_sop    : first symbol of packet
//   st_eop    : last symbol of packet
//   st_error  : tied 0
//   bus_ovf   : sticky, a word was dropped
//   pkt_cnt   : completed output packets, wraps
module bus2st_pp #(
  parameter int BUS_W       = 512,
  parameter int ST_W        = 12,
  parameter int SYM_PER_BUS = 42,
  parameter int SYM_PER_PKT = 1028,
  parameter int BUS_PER_PKT = 25,
  parameter int PKT_CNT_W   = 8
) (
  input  logic                 clk_st,
  input  logic                 rst,
  input  logic [BUS_W-1:0]     bus_data,
  input  logic                 bus_en,
  output logic                 bus_ready,
  input  logic                 st_ready,
  output logic [ST_W-1:0]      st_data,
  output logic                 st_valid,
  output logic                 st_sop,
  output logic                 st_eop,
  output logic                 st_error,
  output logic                 bus_ovf,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  localparam int MEM_W = SYM_PER_BUS * ST_W;
  localparam int DEPTH = 2 * BUS_PER_PKT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW    = $clog2(BUS_PER_PKT + 1);
  localparam int SW    = $clog2(SYM_PER_BUS + 1);
  localparam int BW    = $clog2(SYM_PER_PKT + 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} rd_st_e;

  bank_st_e          bank_st [2];
  logic              wr_bank, rd_bank;
  logic [WW-1:0]     wr_cnt;
  logic              wr_fire;

  rd_st_e            state, state_nxt;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  rd_q;
  logic [MEM_W-1:0]  cur_word;
  logic [WW-1:0]     word_idx;
  logic [SW-1:0]     sym_idx;
  logic [BW-1:0]     beat_cnt;
  logic              accept, word_end;
  logic [WW:0]       rd_word_raw;
  logic [WW-1:0]     rd_word;
  logic [AW-1:0]     wr_addr, rd_addr;

  // Bits of bus_data above the used symbols are ignored.
  generate
    if (BUS_W > MEM_W) begin : g_pad
      logic bus_data_unused;
      assign bus_data_unused = ^bus_data[BUS_W-1:MEM_W];
    end
  endgenerate

  function automatic logic [AW-1:0] addr_of(input logic bank, input logic [WW-1:0] w);
    return bank ? (AW'(BUS_PER_PKT) + AW'(w)) : AW'(w);
  endfunction

  assign bus_ready = (bank_st[wr_bank] != B_FULL);
  assign wr_fire   = bus_en && bus_ready;
  assign wr_addr   = addr_of(wr_bank, wr_cnt);

  assign accept    = st_valid && st_ready;
  assign word_end  = (sym_idx == SW'(SYM_PER_BUS - 1));
  assign st_data   = cur_word[ST_W-1:0];
  assign st_error  = 1'b0;

  // rd_q always holds the word after the one being emitted.  The address is
  // taken from the word index the *next* cycle will use, so the registered
  // read result is ready exactly when a word boundary is crossed.  IDLE
  // pre-reads word 0 so LOAD can latch it.
  always_comb begin
    rd_word_raw = '0;
    case (state)
      S_LOAD:   rd_word_raw = (WW+1)'(1);
      S_STREAM: rd_word_raw = {1'b0, word_idx} +
                              ((accept && word_end) ? (WW+1)'(2) : (WW+1)'(1));
      default:  rd_word_raw = '0;
    endcase
  end

  assign rd_word = (rd_word_raw >= (WW+1)'(BUS_PER_PKT)) ? '0 : WW'(rd_word_raw);
  assign rd_addr = addr_of(rd_bank, rd_word);

  // Bank storage: no reset, one-cycle read latency.
  always_ff @(posedge clk_st) begin
    if (wr_fire) mem[wr_addr] <= bus_data[MEM_W-1:0];
    rd_q <= mem[rd_addr];
  end

  // Read FSM
  always_ff @(posedge clk_st) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bank_st[rd_bank] == B_FULL) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_STREAM;
      S_STREAM: if (accept && st_eop) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bank bookkeeping, write pointer and output datapath.  The writer never
  // touches a FULL bank and the reader only frees a FULL bank, so the two
  // bank_st updates cannot collide on the same entry.
  always_ff @(posedge clk_st) begin
    if (rst) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      bus_ovf    <= 1'b0;
      pkt_cnt    <= '0;
      cur_word   <= '0;
      word_idx   <= '0;
      sym_idx    <= '0;
      beat_cnt   <= '0;
      st_valid   <= 1'b0;
      st_sop     <= 1'b0;
      st_eop     <= 1'b0;
    end else begin
      if (bus_en && !bus_ready) bus_ovf <= 1'b1;

      if (wr_fire) begin
        if (wr_cnt == WW'(BUS_PER_PKT - 1)) begin
          bank_st[wr_bank] <= B_FULL;
          wr_bank          <= ~wr_bank;
          wr_cnt           <= '0;
        end else begin
          bank_st[wr_bank] <= B_FILLING;
          wr_cnt           <= wr_cnt + 1'b1;
        end
      end

      case (state)
        S_LOAD: begin
          cur_word <= rd_q;
          word_idx <= '0;
          sym_idx  <= '0;
          beat_cnt <= '0;
          st_valid <= 1'b1;
          st_sop   <= 1'b1;
          st_eop   <= 1'(SYM_PER_PKT == 1);
        end
        S_STREAM: begin
          if (accept) begin
            st_sop <= 1'b0;
            if (st_eop) begin
              st_valid         <= 1'b0;
              st_eop           <= 1'b0;
              bank_st[rd_bank] <= B_EMPTY;
              rd_bank          <= ~rd_bank;
              pkt_cnt          <= pkt_cnt + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              st_eop   <= (beat_cnt == BW'(SYM_PER_PKT - 2));
              if (word_end) begin
                cur_word <= rd_q;
                sym_idx  <= '0;
                word_idx <= word_idx + 1'b1;
              end else begin
                cur_word <= cur_word >> ST_W;
                sym_idx  <= sym_idx + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus2st_pp.sv
// Scoreboard bench for bus2st_pp (default parameters).  The reference model
// works at packet level: accepted words are split into symbols, every 25
// accepted words become one packet of 1028 expected beats, and a writer may
// only deposit a word while fewer than two packets are waiting or streaming.
module tb_bus2st_pp;

  localparam int BUS_W = 512, ST_W = 12, SPB = 42, SPP = 1028, BPP = 25, PCW = 8;

  logic             clk_st = 1'b0;
  logic             rst = 1'b1;
  logic [BUS_W-1:0] bus_data = '0;
  logic             bus_en = 1'b0;
  logic             bus_ready;
  logic             st_ready = 1'b1;
  logic [ST_W-1:0]  st_data;
  logic             st_valid, st_sop, st_eop, st_error, bus_ovf;
  logic [PCW-1:0]   pkt_cnt;

  bus2st_pp dut (
    .clk_st(clk_st), .rst(rst), .bus_data(bus_data), .bus_en(bus_en),
    .bus_ready(bus_ready), .st_ready(st_ready), .st_data(st_data),
    .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_error(st_error), .bus_ovf(bus_ovf), .pkt_cnt(pkt_cnt)
  );

  always #5 clk_st = ~clk_st;

  typedef struct { logic [ST_W-1:0] d; bit sop; bit eop; } beat_t;

  // Model state (written only by the monitor)
  beat_t           exp_q[$];
  logic [ST_W-1:0] fill[$];
  int              wcnt = 0, full_cnt = 0, acc_total = 0, gap = 0;
  bit              exp_ovf = 0, in_pkt = 0, held = 0, post_rst = 0;
  logic [PCW-1:0]  exp_pkt = '0;
  logic [ST_W-1:0] h_d;
  bit              h_sop, h_eop;
  int              n_chk = 0, n_pass = 0, tmo_seen = 0;
  // Driver-owned
  int              tmo_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor / scoreboard
  always @(negedge clk_st) begin
    bit    pr;
    beat_t e;
    pr = post_rst;
    post_rst = rst;

    if (tmo_cnt != tmo_seen) begin
      chk("wait_timeout", 64'(tmo_cnt), 64'(tmo_seen));
      tmo_seen = tmo_cnt;
    end

    chk("bus_ready", bus_ready, 64'(full_cnt < 2));
    chk("bus_ovf", bus_ovf, exp_ovf);
    chk("pkt_cnt", pkt_cnt, exp_pkt);
    chk("st_error", st_error, 0);
    if (pr) begin
      chk("rst_data", st_data, 0);
      chk("rst_sop", st_sop, 0);
      chk("rst_eop", st_eop, 0);
      chk("rst_valid", st_valid, 0);
    end
    if (held) begin
      chk("hold_valid", st_valid, 1);
      chk("hold_data", st_data, h_d);
      chk("hold_sop", st_sop, h_sop);
      chk("hold_eop", st_eop, h_eop);
    end
    if (in_pkt) chk("valid_in_pkt", st_valid, 1);
    if (st_valid && exp_q.size() == 0) chk("valid_no_pkt", st_valid, 0);

    if (!rst && !st_valid && exp_q.size() != 0) gap++;
    if (st_valid && gap != 0) begin
      chk("restart_gap_gt3", 64'(gap > 3), 0);
      gap = 0;
    end

    if (rst) begin
      exp_q.delete(); fill.delete();
      wcnt = 0; full_cnt = 0; exp_ovf = 0; exp_pkt = '0;
      in_pkt = 0; held = 0; gap = 0;
    end else begin
      // Write side is judged on occupancy before this cycle's eop frees a bank.
      if (bus_en) begin
        if (full_cnt < 2) begin
          for (int k = 0; k < SPB; k++) fill.push_back(bus_data[k*ST_W +: ST_W]);
          wcnt++;
          if (wcnt == BPP) begin
            for (int i = 0; i < SPP; i++) exp_q.push_back('{fill[i], i == 0, i == SPP-1});
            fill.delete();
            wcnt = 0;
            full_cnt++;
          end
        end else exp_ovf = 1;
      end
      if (st_valid && st_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data", st_data, e.d);
        chk("sop", st_sop, e.sop);
        chk("eop", st_eop, e.eop);
        acc_total++;
        if (e.eop) begin
          full_cnt--;
          exp_pkt = exp_pkt + 1'b1;
          in_pkt = 0;
        end else in_pkt = 1;
      end
      held = st_valid && !st_ready;
      h_d = st_data; h_sop = st_sop; h_eop = st_eop;
    end
  end

  function automatic logic [BUS_W-1:0] seq_word(input int w);
    logic [BUS_W-1:0] d = '0;
    for (int k = 0; k < SPB; k++) d[k*ST_W +: ST_W] = 12'((w*SPB + k) % 4096);
    return d;
  endfunction

  function automatic logic [BUS_W-1:0] rnd_word();
    logic [BUS_W-1:0] d;
    for (int i = 0; i < BUS_W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk_st); #1;
  endtask

  task automatic do_rst();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic burst(input int n, input bit seq);
    for (int i = 0; i < n; i++) begin
      bus_data = seq ? seq_word(i) : rnd_word();
      bus_en = 1'b1;
      tick();
    end
    bus_en = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int t = 0;
    while ((exp_q.size() != 0 || full_cnt != 0 || st_valid) && t < 12000) begin
      st_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(); t++;
    end
    st_ready = 1'b1;
    if (t >= 12000) tmo_cnt++;
  endtask

  initial begin
    int n, t, base;
    rst = 1'b1;
    repeat (3) @(posedge clk_st);
    #1 rst = 1'b0;
    tick();

    // Sequential-pattern packet, sink always ready
    st_ready = 1'b1;
    burst(25, 1'b1);
    drain(1'b0);

    // Two packets back to back
    burst(50, 1'b0);
    drain(1'b0);

    // Stalled sink: both banks fill, later words dropped
    do_rst();
    st_ready = 1'b0;
    burst(75, 1'b0);
    repeat (20) tick();
    drain(1'b0);

    // Random backpressure and bursty writer, four packets
    do_rst();
    n = 0; t = 0;
    while (n < 100 && t < 20000) begin
      st_ready = 1'($urandom_range(0, 1));
      if (bus_ready && $urandom_range(0, 3) != 0) begin
        bus_data = rnd_word(); bus_en = 1'b1; n++;
      end else bus_en = 1'b0;
      tick(); t++;
    end
    bus_en = 1'b0;
    if (n < 100) tmo_cnt++;
    drain(1'b1);

    // Reset while beat 500 is on the bus, then a clean packet
    do_rst();
    base = acc_total;
    burst(25, 1'b0);
    t = 0;
    while (acc_total - base < 500 && t < 3000) begin tick(); t++; end
    if (t >= 3000) tmo_cnt++;
    do_rst();
    burst(25, 1'b1);
    drain(1'b0);

    // Write lands on the bank being freed by this cycle's eop
    do_rst();
    st_ready = 1'b0;
    burst(50, 1'b0);
    st_ready = 1'b1;
    t = 0;
    while (!(st_valid && st_eop) && t < 3000) begin tick(); t++; end
    if (t >= 3000) tmo_cnt++;
    bus_data = rnd_word(); bus_en = 1'b1;
    tick();
    bus_en = 1'b0;
    tick();
    burst(25, 1'b0);
    drain(1'b0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
